// File: rtl/cv32e40x_xif_reorder_buffer.sv
// cv32e40x_xif_reorder_buffer
//
// Reorders coprocessor (X-interface) results back into offload issue order.
// Offloads are allocated in issue order into a circular buffer. Results may
// arrive in any order and are matched by instruction ID. Entries can be killed
// by the commit stage. Completed entries leave in order, one per cycle.
//
// Optional feature macro: XIF_RESULT_BYPASS_EN
//   When defined, a result that completes the head entry is presented on
//   out_* in the same cycle. If out_ready_i is high it pops without being
//   stored. When undefined, res_* never reach out_* combinationally and the
//   result-to-output latency is one cycle.
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both high. A valid, once raised, holds with stable payload until it is
// accepted. The one exception is a killed head entry, which is withdrawn.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   alloc_valid/ready/id   new offload awaiting writeback, in issue order
//   res_valid/ready/id/rd/we/data  coprocessor result, any order; res_ready_o is always 1
//   kill_valid/id          marks the oldest live entry with that id as killed
//   out_valid/ready/id/rd/we/data  in-order result towards CPU writeback
//   count_o                number of live entries
module cv32e40x_xif_reorder_buffer #(
  parameter int X_ID_WIDTH  = 4,
  parameter int DEPTH       = 4,
  parameter int X_RFW_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       alloc_valid_i,
  output logic                       alloc_ready_o,
  input  logic [X_ID_WIDTH-1:0]      alloc_id_i,
  input  logic                       res_valid_i,
  output logic                       res_ready_o,
  input  logic [X_ID_WIDTH-1:0]      res_id_i,
  input  logic [4:0]                 res_rd_i,
  input  logic                       res_we_i,
  input  logic [X_RFW_WIDTH-1:0]     res_data_i,
  input  logic                       kill_valid_i,
  input  logic [X_ID_WIDTH-1:0]      kill_id_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [X_ID_WIDTH-1:0]      out_id_o,
  output logic [4:0]                 out_rd_o,
  output logic                       out_we_o,
  output logic [X_RFW_WIDTH-1:0]     out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]       valid_q, done_q, killed_q;
  logic [X_ID_WIDTH-1:0]  id_q   [DEPTH];
  logic [4:0]             rd_q   [DEPTH];
  logic                   we_q   [DEPTH];
  logic [X_RFW_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]          head_q, tail_q;
  logic [CW-1:0]          count_q;

  logic          res_hit, kill_hit;
  logic [PW-1:0] res_idx, kill_idx, scan_idx;
  logic          res_fire, kill_fire, head_kill_now, stored_out, bypass;
  logic          alloc_fire, pop, store_res;

  // Age-ordered search starting at head; DEPTH is a power of two so the
  // pointer addition wraps naturally. First hit is the oldest entry.
  always_comb begin
    res_hit  = 1'b0;
    res_idx  = '0;
    kill_hit = 1'b0;
    kill_idx = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PW'(k);
      if (!res_hit && valid_q[scan_idx] && !done_q[scan_idx] &&
          !killed_q[scan_idx] && (id_q[scan_idx] == res_id_i)) begin
        res_hit = 1'b1;
        res_idx = scan_idx;
      end
      if (!kill_hit && valid_q[scan_idx] && (id_q[scan_idx] == kill_id_i)) begin
        kill_hit = 1'b1;
        kill_idx = scan_idx;
      end
    end
  end

  // A kill and a result naming the same id in one cycle: the kill wins.
  assign kill_fire     = kill_valid_i && kill_hit;
  assign res_fire      = res_valid_i && res_hit && !(kill_valid_i && (kill_id_i == res_id_i));
  assign head_kill_now = kill_fire && (kill_idx == head_q);
  assign stored_out    = valid_q[head_q] && done_q[head_q] && !killed_q[head_q] && !head_kill_now;

`ifdef XIF_RESULT_BYPASS_EN
  // res_fire already excludes done/killed entries and same-id kills.
  assign bypass = res_fire && (res_idx == head_q);
`else
  assign bypass = 1'b0;
`endif

  assign out_valid_o = stored_out || bypass;
  assign out_id_o    = id_q[head_q];
  assign out_rd_o    = bypass ? res_rd_i   : rd_q[head_q];
  assign out_we_o    = bypass ? res_we_i   : we_q[head_q];
  assign out_data_o  = bypass ? res_data_i : data_q[head_q];

  assign res_ready_o   = 1'b1;
  assign alloc_ready_o = (count_q < CW'(DEPTH));
  assign count_o       = count_q;

  assign alloc_fire = alloc_valid_i && alloc_ready_o;
  // A killed head drains on its own without ever raising out_valid_o.
  assign pop        = (out_valid_o && out_ready_i) || (valid_q[head_q] && killed_q[head_q]);
  assign store_res  = res_fire && !(bypass && out_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      done_q   <= '0;
      killed_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]   <= '0;
        rd_q[i]   <= '0;
        we_q[i]   <= 1'b0;
        data_q[i] <= '0;
      end
    end else begin
      if (alloc_fire) begin
        valid_q[tail_q]  <= 1'b1;
        done_q[tail_q]   <= 1'b0;
        killed_q[tail_q] <= 1'b0;
        id_q[tail_q]     <= alloc_id_i;
        tail_q           <= tail_q + PW'(1);
      end
      if (store_res) begin
        done_q[res_idx] <= 1'b1;
        rd_q[res_idx]   <= res_rd_i;
        we_q[res_idx]   <= res_we_i;
        data_q[res_idx] <= res_data_i;
      end
      if (kill_fire) begin
        killed_q[kill_idx] <= 1'b1;
      end
      // Alloc never targets the head while it is live (full blocks alloc),
      // so clearing valid here cannot collide with a new allocation.
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (alloc_fire && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!alloc_fire && pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cv32e40x_xif_reorder_buffer.sv
// Directed testbench for cv32e40x_xif_reorder_buffer (default parameters).
// Inputs change 1 ns after a rising edge; outputs are sampled 2 ns later.
module tb_cv32e40x_xif_reorder_buffer;

  localparam int IW = 4;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          alloc_valid_i, alloc_ready_o;
  logic [IW-1:0] alloc_id_i;
  logic          res_valid_i, res_ready_o;
  logic [IW-1:0] res_id_i;
  logic [4:0]    res_rd_i;
  logic          res_we_i;
  logic [DW-1:0] res_data_i;
  logic          kill_valid_i;
  logic [IW-1:0] kill_id_i;
  logic          out_valid_o, out_ready_i;
  logic [IW-1:0] out_id_o;
  logic [4:0]    out_rd_o;
  logic          out_we_o;
  logic [DW-1:0] out_data_o;
  logic [2:0]    count_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [IW-1:0] exp_q[$];

  cv32e40x_xif_reorder_buffer #(.X_ID_WIDTH(IW), .DEPTH(4), .X_RFW_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_id_i(alloc_id_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_id_i(res_id_i),
    .res_rd_i(res_rd_i), .res_we_i(res_we_i), .res_data_i(res_data_i),
    .kill_valid_i(kill_valid_i), .kill_id_i(kill_id_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_id_o(out_id_o),
    .out_rd_o(out_rd_o), .out_we_o(out_we_o), .out_data_o(out_data_o),
    .count_o(count_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs;
    alloc_valid_i = 1'b0; alloc_id_i = '0;
    res_valid_i = 1'b0; res_id_i = '0; res_rd_i = '0; res_we_i = 1'b0; res_data_i = '0;
    kill_valid_i = 1'b0; kill_id_i = '0;
    out_ready_i = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_alloc(input logic [IW-1:0] id);
    alloc_valid_i = 1'b1; alloc_id_i = id;
    tick();
    alloc_valid_i = 1'b0;
  endtask

  task automatic set_res(input logic [IW-1:0] id, input logic [DW-1:0] data);
    res_valid_i = 1'b1; res_id_i = id; res_rd_i = 5'(id); res_we_i = 1'b1; res_data_i = data;
  endtask

  // Pops every expected id in order within a cycle budget.
  task automatic drain_expect;
    logic [IW-1:0] e;
    out_ready_i = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      #2;
      if (out_valid_o) begin
        e = exp_q.pop_front();
        total_cnt++;
        if (out_id_o !== e) $display("FAIL drain_id: got %0d want %0d", out_id_o, e); else pass_cnt++;
      end
      tick();
    end
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL drain_timeout: left %0d want 0", exp_q.size()); else pass_cnt++;
    exp_q.delete();
    #2;
    total_cnt++;
    if (count_o !== 3'd0) $display("FAIL drain_count: got %0d want 0", count_o); else pass_cnt++;
    total_cnt++;
    if (out_valid_o !== 1'b0) $display("FAIL drain_extra_out: got %b want 0", out_valid_o); else pass_cnt++;
    tick();
    out_ready_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #2;
    total_cnt++; if (count_o !== 3'd0) $display("FAIL reset_count: got %0d want 0", count_o); else pass_cnt++;
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid_o); else pass_cnt++;
    total_cnt++; if (alloc_ready_o !== 1'b1) $display("FAIL reset_alloc_ready: got %b want 1", alloc_ready_o); else pass_cnt++;
    total_cnt++; if (res_ready_o !== 1'b1) $display("FAIL reset_res_ready: got %b want 1", res_ready_o); else pass_cnt++;
    tick();
  endtask

  task automatic test_in_order;
    drive_alloc(4'd1); drive_alloc(4'd2); drive_alloc(4'd3);
    out_ready_i = 1'b1;
    set_res(4'd3, 32'hA000_0003); #2;
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL order_r3_out: got %b want 0", out_valid_o); else pass_cnt++;
    tick();
    set_res(4'd1, 32'hA000_0001); #2;
`ifdef XIF_RESULT_BYPASS_EN
    total_cnt++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd1 || out_data_o !== 32'hA000_0001)
      $display("FAIL order_byp1: got v=%b id=%0d d=%h want v=1 id=1 d=a0000001", out_valid_o, out_id_o, out_data_o); else pass_cnt++;
    tick();
    set_res(4'd2, 32'hA000_0002); #2;
    total_cnt++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd2 || out_data_o !== 32'hA000_0002)
      $display("FAIL order_byp2: got v=%b id=%0d d=%h want v=1 id=2", out_valid_o, out_id_o, out_data_o); else pass_cnt++;
    tick();
    res_valid_i = 1'b0; #2;
`else
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL order_r1_out: got %b want 0", out_valid_o); else pass_cnt++;
    tick();
    set_res(4'd2, 32'hA000_0002); #2;
    total_cnt++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd1 || out_data_o !== 32'hA000_0001 || out_rd_o !== 5'd1 || out_we_o !== 1'b1)
      $display("FAIL order_out1: got v=%b id=%0d d=%h want v=1 id=1 d=a0000001", out_valid_o, out_id_o, out_data_o); else pass_cnt++;
    tick();
    res_valid_i = 1'b0; #2;
    total_cnt++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd2 || out_data_o !== 32'hA000_0002)
      $display("FAIL order_out2: got v=%b id=%0d d=%h want v=1 id=2", out_valid_o, out_id_o, out_data_o); else pass_cnt++;
    tick(); #2;
`endif
    total_cnt++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd3 || out_data_o !== 32'hA000_0003)
      $display("FAIL order_out3: got v=%b id=%0d d=%h want v=1 id=3", out_valid_o, out_id_o, out_data_o); else pass_cnt++;
    tick(); #2;
    total_cnt++; if (count_o !== 3'd0 || out_valid_o !== 1'b0)
      $display("FAIL order_empty: got cnt=%0d v=%b want cnt=0 v=0", count_o, out_valid_o); else pass_cnt++;
    idle_inputs();
    tick();
  endtask

  task automatic test_full;
    for (int i = 0; i < 4; i++) drive_alloc(4'(i));
    alloc_valid_i = 1'b1; alloc_id_i = 4'd9; #2;
    total_cnt++; if (alloc_ready_o !== 1'b0) $display("FAIL full_alloc_ready: got %b want 0", alloc_ready_o); else pass_cnt++;
    total_cnt++; if (count_o !== 3'd4) $display("FAIL full_count: got %0d want 4", count_o); else pass_cnt++;
    tick();
    alloc_valid_i = 1'b0; #2;
    total_cnt++; if (count_o !== 3'd4) $display("FAIL full_fifth_ignored: got %0d want 4", count_o); else pass_cnt++;
    set_res(4'd0, 32'h0000_0F00);
    tick();
    res_valid_i = 1'b0; out_ready_i = 1'b1; #2;
    total_cnt++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd0) $display("FAIL full_pop_out: got v=%b id=%0d want v=1 id=0", out_valid_o, out_id_o); else pass_cnt++;
    tick();
    out_ready_i = 1'b0; #2;
    total_cnt++; if (alloc_ready_o !== 1'b1) $display("FAIL full_ready_after_pop: got %b want 1", alloc_ready_o); else pass_cnt++;
    total_cnt++; if (count_o !== 3'd3) $display("FAIL full_count_after_pop: got %0d want 3", count_o); else pass_cnt++;
    for (int i = 1; i < 4; i++) begin
      set_res(4'(i), 32'(i));
      tick();
    end
    res_valid_i = 1'b0;
    exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
    drain_expect();
  endtask

  task automatic test_kill;
    drive_alloc(4'd5); drive_alloc(4'd6);
    kill_valid_i = 1'b1; kill_id_i = 4'd5; #2;
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL kill_cycle_out: got %b want 0", out_valid_o); else pass_cnt++;
    tick();
    kill_valid_i = 1'b0; out_ready_i = 1'b1;
    set_res(4'd6, 32'hDEAD_BEEF); #2;
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL kill_head_hidden: got %b want 0", out_valid_o); else pass_cnt++;
    total_cnt++; if (count_o !== 3'd2) $display("FAIL kill_count2: got %0d want 2", count_o); else pass_cnt++;
    tick();
    res_valid_i = 1'b0; #2;
    total_cnt++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd6 || out_data_o !== 32'hDEAD_BEEF)
      $display("FAIL kill_next_out: got v=%b id=%0d d=%h want v=1 id=6 d=deadbeef", out_valid_o, out_id_o, out_data_o); else pass_cnt++;
    total_cnt++; if (count_o !== 3'd1) $display("FAIL kill_count1: got %0d want 1", count_o); else pass_cnt++;
    tick(); #2;
    total_cnt++; if (count_o !== 3'd0 || out_valid_o !== 1'b0)
      $display("FAIL kill_empty: got cnt=%0d v=%b want cnt=0 v=0", count_o, out_valid_o); else pass_cnt++;
    idle_inputs();
    tick();
  endtask

  task automatic test_kill_and_result;
    drive_alloc(4'd7);
    out_ready_i = 1'b1;
    kill_valid_i = 1'b1; kill_id_i = 4'd7;
    set_res(4'd7, 32'h7777_7777); #2;
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL kr_same_cycle_out: got %b want 0", out_valid_o); else pass_cnt++;
    tick();
    kill_valid_i = 1'b0; res_valid_i = 1'b0; #2;
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL kr_killed_out: got %b want 0", out_valid_o); else pass_cnt++;
    total_cnt++; if (count_o !== 3'd1) $display("FAIL kr_count1: got %0d want 1", count_o); else pass_cnt++;
    tick(); #2;
    total_cnt++; if (count_o !== 3'd0 || out_valid_o !== 1'b0)
      $display("FAIL kr_popped: got cnt=%0d v=%b want cnt=0 v=0", count_o, out_valid_o); else pass_cnt++;
    idle_inputs();
    tick();
  endtask

  task automatic test_latency;
    drive_alloc(4'd2);
    out_ready_i = 1'b1;
    set_res(4'd2, 32'h0000_0012); #2;
`ifdef XIF_RESULT_BYPASS_EN
    total_cnt++; if (out_valid_o !== 1'b1 || out_data_o !== 32'h12)
      $display("FAIL lat_bypass_out: got v=%b d=%h want v=1 d=12", out_valid_o, out_data_o); else pass_cnt++;
    tick();
    res_valid_i = 1'b0; #2;
`else
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL lat_no_comb_path: got %b want 0", out_valid_o); else pass_cnt++;
    tick();
    res_valid_i = 1'b0; #2;
    total_cnt++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd2 || out_data_o !== 32'h12)
      $display("FAIL lat_out_next: got v=%b id=%0d d=%h want v=1 id=2 d=12", out_valid_o, out_id_o, out_data_o); else pass_cnt++;
    tick(); #2;
`endif
    total_cnt++; if (count_o !== 3'd0) $display("FAIL lat_count: got %0d want 0", count_o); else pass_cnt++;
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back;
    drive_alloc(4'd1);
    set_res(4'd1, 32'h0000_00B1);
    tick();
    res_valid_i = 1'b0;
    out_ready_i = 1'b1; alloc_valid_i = 1'b1; alloc_id_i = 4'd2; #2;
    total_cnt++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd1 || out_data_o !== 32'hB1)
      $display("FAIL b2b_out: got v=%b id=%0d d=%h want v=1 id=1 d=b1", out_valid_o, out_id_o, out_data_o); else pass_cnt++;
    total_cnt++; if (count_o !== 3'd1) $display("FAIL b2b_count_before: got %0d want 1", count_o); else pass_cnt++;
    tick();
    alloc_valid_i = 1'b0; out_ready_i = 1'b0; #2;
    total_cnt++; if (count_o !== 3'd1) $display("FAIL b2b_count_after: got %0d want 1", count_o); else pass_cnt++;
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL b2b_out_after: got %b want 0", out_valid_o); else pass_cnt++;
    set_res(4'd2, 32'h0000_00B2);
    tick();
    res_valid_i = 1'b0;
    exp_q.push_back(4'd2);
    drain_expect();
  endtask

  task automatic test_reset_mid;
    drive_alloc(4'd10); drive_alloc(4'd11); drive_alloc(4'd12);
    #2;
    total_cnt++; if (count_o !== 3'd3) $display("FAIL rmid_count_before: got %0d want 3", count_o); else pass_cnt++;
    rst_ni = 1'b0; #1;
    total_cnt++; if (count_o !== 3'd0) $display("FAIL rmid_count_async: got %0d want 0", count_o); else pass_cnt++;
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL rmid_out_async: got %b want 0", out_valid_o); else pass_cnt++;
    total_cnt++; if (alloc_ready_o !== 1'b1) $display("FAIL rmid_alloc_ready: got %b want 1", alloc_ready_o); else pass_cnt++;
    tick(); tick();
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    for (int i = 10; i < 13; i++) begin
      set_res(4'(i), 32'(i)); #2;
      total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL rmid_stale_out: got %b want 0 (id %0d)", out_valid_o, i); else pass_cnt++;
      tick();
    end
    res_valid_i = 1'b0; #2;
    total_cnt++; if (count_o !== 3'd0 || out_valid_o !== 1'b0)
      $display("FAIL rmid_final: got cnt=%0d v=%b want cnt=0 v=0", count_o, out_valid_o); else pass_cnt++;
    idle_inputs();
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    test_reset();
    test_in_order();
    test_full();
    test_kill();
    test_kill_and_result();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cv32e40x_xif_reorder_buffer.md
CV32E40X_XIF_REORDER_BUFFER -- requirements
Module: cv32e40x_xif_reorder_buffer

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default 4, width of the offload instruction ID.
REQ-002 SHALL have parameter DEPTH, default 4, number of outstanding entries (power of two, 2..16).
REQ-003 SHALL have parameter X_RFW_WIDTH, default 32, result data width.
REQ-004 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports alloc_valid_i input 1, alloc_ready_o output 1, alloc_id_i input X_ID_WIDTH: accepted offload awaiting writeback, in issue order.
REQ-007 SHALL have ports res_valid_i input 1, res_ready_o output 1, res_id_i input X_ID_WIDTH, res_rd_i input 5, res_we_i input 1, res_data_i input X_RFW_WIDTH: coprocessor result, any order.
REQ-008 SHALL have ports kill_valid_i input 1, kill_id_i input X_ID_WIDTH: commit-kill of an entry.
REQ-009 SHALL have ports out_valid_o output 1, out_ready_i input 1, out_id_o output X_ID_WIDTH, out_rd_o output 5, out_we_o output 1, out_data_o output X_RFW_WIDTH: in-order result to CPU writeback.
REQ-010 SHALL have port count_o  output  $clog2(DEPTH+1)  live entry count.

Function
REQ-011 SHALL hold entries in a circular buffer (head, tail pointers wrapping modulo DEPTH); each entry: valid, id, done, killed, rd, we, data.
REQ-012 alloc_ready_o SHALL equal (count_o < DEPTH), independent of same-cycle pop; alloc fires on alloc_valid_i && alloc_ready_o, writes tail with done=0, killed=0.
REQ-013 res_ready_o SHALL be constant 1; a result writes the oldest valid, not-done, not-killed entry with matching id and sets done; unmatched results are dropped.
REQ-014 kill SHALL set killed on the oldest valid entry with matching id; kill and result for the same id in one cycle: kill wins, result dropped.
REQ-015 out_valid_o SHALL be 1 when head is valid, done, not killed, and not killed this cycle; out_* fields driven from head entry.
REQ-016 Pop on out_valid_o && out_ready_i; a killed head SHALL be popped automatically in one cycle without asserting out_valid_o.
REQ-017 Simultaneous alloc and pop SHALL leave count_o unchanged; pointers each advance by one.
REQ-018 Default result-to-output latency SHALL be one cycle (result written at edge, out_valid_o next cycle).
REQ-019 out_valid_o SHALL stay asserted with stable fields until accepted (unless killed).

Reset
REQ-020 On rst_ni low, asynchronously: all entries invalid, head=tail=0, count_o=0, out_valid_o=0, alloc_ready_o=1 after reset.
REQ-021 Reset mid-operation SHALL discard all outstanding entries; no output for them after release.

Configuration
REQ-022 Macro XIF_RESULT_BYPASS_EN SHALL enable same-cycle bypass: result matching a valid, not-done, not-killed head drives out_valid_o and out_* combinationally in that cycle; if out_ready_i, entry pops without being stored, else stored as in REQ-013.
REQ-023 Without XIF_RESULT_BYPASS_EN, no combinational path from res_* to out_*; latency per REQ-018.

Verification
REQ-024 Alloc ids 1,2,3; results 3,1,2 on consecutive cycles, out_ready_i=1 -> outputs ids 1,2,3 in order, with 1 one cycle after its result, 2 and 3 back to back.
REQ-025 Alloc DEPTH=4 ids 0..3 -> alloc_ready_o=0, count_o=4; fifth alloc ignored; pop one -> alloc_ready_o=1 next cycle.
REQ-026 Alloc 5,6; kill 5; result 6 data 0xDEADBEEF -> head 5 dropped without out_valid_o, then out id 6 data 0xDEADBEEF.
REQ-027 Kill id 7 and result id 7 same cycle -> entry killed, no output, count_o decrements when popped.
REQ-028 With XIF_RESULT_BYPASS_EN: alloc 2, result 2 data 0x12 with out_ready_i=1 -> out_valid_o same cycle, count_o 0 next cycle; without macro -> out_valid_o one cycle later.
REQ-029 Assert rst_ni low with 3 entries pending -> count_o=0, out_valid_o=0 immediately; later results for those ids dropped.
